// File: rtl/ascon_dec_ctrl_pkg.sv
// Shared types and constants for the Ascon decryption sequencer.
package ascon_dec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DELAY = 3'd4,
    ST_READ  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam int RND_W = 17;
  localparam logic [RND_W-1:0] LFSR_SEED = 17'h1ACE5;
  localparam int LFSR_TAP_A = 17;
  localparam int LFSR_TAP_B = 14;

  // Serial transfer length: the widest operand, never shorter than the 128-bit nonce/tag.
  function automatic int calc_max(input int k, input int l, input int y);
    int m;
    m = 128;
    if (k > m) m = k;
    if (l > m) m = l;
    if (y > m) m = y;
    return m;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ascon_dec_ctrl_lfsr.sv
// 17-bit Fibonacci LFSR (taps 17,14) supplying per-cycle share randomness.
module ascon_dec_ctrl_lfsr
  import ascon_dec_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [RND_W-1:0] rnd_o
);

  logic [RND_W-1:0] lfsr_q;
  logic [RND_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[RND_W-2:0], lfsr_q[LFSR_TAP_A-1] ^ lfsr_q[LFSR_TAP_B-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q;

endmodule

// File: rtl/ascon_dec_ctrl.sv
// Host-side sequencer for the bit-serial Ascon decryption core.
// Define ASCON_DEC_CTRL_LFSR_EN to drive share randomness from an LFSR; otherwise it is tied to 0.
module ascon_dec_ctrl
  import ascon_dec_ctrl_pkg::*;
#(
  parameter int K            = 128,
  parameter int L            = 40,
  parameter int Y            = 80,
  parameter int START_CYCLES = 3,
  parameter int READ_DELAY   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  key_i,
  input  logic [127:0]  nonce_i,
  input  logic [L-1:0]  ad_i,
  input  logic [Y-1:0]  ct_i,
  output logic [2:0]    keyxSI,
  output logic [2:0]    noncexSI,
  output logic [2:0]    associated_dataxSI,
  output logic [2:0]    cipher_textxSI,
  output logic [6:0]    r_64xSI,
  output logic          r_128xSI,
  output logic          r_ptxSI,
  output logic          decryption_startxSI,
  input  logic          plain_textxSO,
  input  logic          tagxSO,
  input  logic          decryption_readyxSO,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Y-1:0]  pt_o,
  output logic [127:0]  tag_o,
  output logic [15:0]   cycles_o,
  output state_e        dbg_state_o
);

  localparam int MAX   = calc_max(K, L, Y);
  localparam int CNT_W = $clog2(MAX + START_CYCLES + READ_DELAY + 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(MAX - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] PT_LIM     = CNT_W'(Y);
  localparam logic [CNT_W-1:0] TAG_LIM    = CNT_W'(128);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [K-1:0]      key_sh_q, key_sh_d;
  logic [127:0]      nonce_sh_q, nonce_sh_d;
  logic [L-1:0]      ad_sh_q, ad_sh_d;
  logic [Y-1:0]      ct_sh_q, ct_sh_d;
  logic [Y-1:0]      pt_q, pt_d;
  logic [127:0]      tag_q, tag_d;
  logic [15:0]       cyc_q, cyc_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              start_q, start_d;
  logic [RND_W-1:0]  rnd;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_sh_q    <= '0;
      nonce_sh_q  <= '0;
      ad_sh_q     <= '0;
      ct_sh_q     <= '0;
      pt_q        <= '0;
      tag_q       <= '0;
      cyc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_sh_q    <= key_sh_d;
      nonce_sh_q  <= nonce_sh_d;
      ad_sh_q     <= ad_sh_d;
      ct_sh_q     <= ct_sh_d;
      pt_q        <= pt_d;
      tag_q       <= tag_d;
      cyc_q       <= cyc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == XFER_LAST) begin
          state_d = ST_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (decryption_readyxSO) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
        end
      end
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_q == XFER_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands shift out MSB first with zero fill, so short operands read as 0 once exhausted
  // and every shift register is empty by the end of LOAD.
  always_comb begin
    key_sh_d    = key_sh_q;
    nonce_sh_d  = nonce_sh_q;
    ad_sh_d     = ad_sh_q;
    ct_sh_d     = ct_sh_q;
    pt_d        = pt_q;
    tag_d       = tag_q;
    cyc_d       = cyc_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    start_d     = (state_d == ST_START);
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          key_sh_d   = key_i;
          nonce_sh_d = nonce_i;
          ad_sh_d    = ad_i;
          ct_sh_d    = ct_i;
        end
      end
      ST_LOAD: begin
        key_sh_d   = {key_sh_q[K-2:0], 1'b0};
        nonce_sh_d = {nonce_sh_q[126:0], 1'b0};
        ad_sh_d    = {ad_sh_q[L-2:0], 1'b0};
        ct_sh_d    = {ct_sh_q[Y-2:0], 1'b0};
      end
      ST_START: begin
        // The count restarts on the first START cycle and covers START plus WAIT.
        cyc_d = (cnt_q == '0) ? 16'd1 : sat_inc16(cyc_q);
      end
      ST_WAIT: begin
        cyc_d = sat_inc16(cyc_q);
      end
      ST_READ: begin
        // Right-shift capture lands sample i at bit i once the register has been filled.
        if (cnt_q < PT_LIM)  pt_d  = {plain_textxSO, pt_q[Y-1:1]};
        if (cnt_q < TAG_LIM) tag_d = {tagxSO, tag_q[127:1]};
      end
      default: ;
    endcase
  end

`ifdef ASCON_DEC_CTRL_LFSR_EN
  ascon_dec_ctrl_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .rnd_o (rnd)
  );
`else
  assign rnd = '0;
`endif

  assign keyxSI              = {rnd[7:6], key_sh_q[K-1]};
  assign associated_dataxSI  = {rnd[5:4], ad_sh_q[L-1]};
  assign cipher_textxSI      = {rnd[3:2], ct_sh_q[Y-1]};
  assign noncexSI            = {rnd[1:0], nonce_sh_q[127]};
  assign r_128xSI            = rnd[16];
  assign r_ptxSI             = rnd[15];
  assign r_64xSI             = rnd[14:8];
  assign decryption_startxSI = start_q;
  assign in_ready            = in_ready_q;
  assign out_valid           = out_valid_q;
  assign pt_o                = pt_q;
  assign tag_o               = tag_q;
  assign cycles_o            = cyc_q;
  assign dbg_state_o         = state_q;

endmodule

// File: doc/ascon_dec_ctrl.md
# ascon_dec_ctrl

Sequencer for the bit-serial Ascon decryption core. It takes parallel key, nonce, associated data and ciphertext from a host through a valid/ready handshake and shifts them into the core's serial inputs. It then pulses the core's start, waits for its ready, and shifts plaintext and tag back out into parallel registers. It also supplies the per-cycle share randomness the core's serial inputs require.

## Interface
Parameters:
- K, 128, key width in bits
- L, 40, associated-data width
- Y, 80, ciphertext/plaintext width
- START_CYCLES, 3, cycles decryption_startxSI is held high
- READ_DELAY, 4, cycles between ready and first output sample
- MAX (localparam), max(K, L, Y, 128), serial transfer length

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- in_valid, in, 1, host operands valid
- in_ready, out, 1, controller idle and accepting
- key_i, in, K, key
- nonce_i, in, 128, nonce
- ad_i, in, L, associated data
- ct_i, in, Y, ciphertext
- keyxSI / noncexSI / associated_dataxSI / cipher_textxSI, out, 3 each, serial data in bit 0, randomness in bits 2:1
- r_64xSI, out, 7, randomness
- r_128xSI, r_ptxSI, out, 1 each, randomness
- decryption_startxSI, out, 1, core start
- plain_textxSO, tagxSO, in, 1 each, core serial outputs
- decryption_readyxSO, in, 1, core done
- out_valid, out, 1, pt/tag valid
- out_ready, in, 1, host consumes result
- pt_o, out, Y, plaintext
- tag_o, out, 128, tag
- cycles_o, out, 16, start-to-ready latency, saturating

## Operation
- States: IDLE, LOAD, START, WAIT, DELAY, READ, DONE.
- IDLE: in_ready=1. When in_valid=1, latch all four operands, clear bit counter i, go to LOAD.
- LOAD: MAX cycles, i=0..MAX-1.
  - Drive keyxSI[0]=key[K-1-i], noncexSI[0]=nonce[127-i], cipher_textxSI[0]=ct[Y-1-i], associated_dataxSI[0]=ad[L-1-i].
  - Any index <0 drives 0.
  - After i=MAX-1, go to START.
- START: decryption_startxSI=1 for START_CYCLES cycles; clear cycles_o on the first START cycle; then go to WAIT.
- WAIT: increment cycles_o each cycle, saturating at 0xFFFF. decryption_readyxSO=1 goes to DELAY.
  - Ready is sampled only in WAIT; ready seen in any other state is ignored.
- DELAY: READ_DELAY cycles, then READ with i=0.
- READ: MAX cycles; at cycle i capture pt_o[i]=plain_textxSO and tag_o[i]=tagxSO. Indices ≥ width are discarded. The result is LSB-first by index.
- DONE: out_valid=1, with pt_o, tag_o and cycles_o stable. out_ready=1 returns to IDLE; in_valid is not accepted in that same cycle.
- Serial data bits are 0 outside LOAD. Randomness outputs are driven every cycle in all states.
- No hang protection: WAIT persists until ready or rst.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, decryption_startxSI=0
  - all xSI data bits 0
  - pt_o=0, tag_o=0, cycles_o=0
  - LFSR=seed 0x1ACE5
- All outputs are registered.
- Accept-to-first-serial-bit: 1 cycle.
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. Operands must be stable only in the accept cycle.
- Total latency, accept to out_valid: 1 + MAX + START_CYCLES + W + READ_DELAY + MAX, where W = WAIT cycles. W ≥ 1.
- rst mid-operation, in any state: return to reset values on the next edge; the core is not notified beyond start dropping.

## Configuration
- ASCON_DEC_CTRL_LFSR_EN defined: a 17-bit Fibonacci LFSR (taps 17,14), advanced every cycle, drives the 17 randomness bits. Bit order: {r_128, r_pt, r_64[6:0], key[2:1], ad[2:1], ct[2:1], nonce[2:1]}.
- Undefined: all 17 randomness bits are tied to 0 (non-TI core builds). No LFSR flops are present.

## Structure
- Package ascon_dec_ctrl_pkg:
  - state enum
  - RND_W=17
  - LFSR_SEED
  - LFSR tap constants
  - function for the MAX computation
- Sub-module ascon_dec_ctrl_lfsr (seed, advance, 17-bit output), instantiated only under the macro.

## Test plan
- Reset, then idle 5 cycles -> in_ready=1, out_valid=0, start=0, all xSI=0, cycles_o=0.
- Load with defaults: K=2db083053e848cefa30007336c47a5a1, N=3f3607dbce3503ba84f5843d623de056, AD=4153434f4e, CT=87a59a2ea49b233259e3.
  - First LOAD cycle: key/nonce/ad/ct bit0 = 0/0/0/1.
  - LOAD lasts exactly 128 cycles; AD bits are 0 from i=40 and CT bits 0 from i=80.
- Core stub raises ready 50 cycles after start falls.
  - Result: start high for exactly 3 cycles, cycles_o=53, first READ sample 4 cycles after ready.
- Stub streams plain_textxSO=1 at i=0 only and tagxSO=1 at i=127 only -> pt_o=1, tag_o=1<<127, out_valid held until out_ready.
- Ready pulsed during LOAD and START -> ignored; controller still waits in WAIT.
- rst asserted mid-READ -> next cycle all outputs at reset values.
- A new transaction then completes normally.
- With the macro: randomness bits change cycle to cycle and the first value is derived from 0x1ACE5.
- Without the macro: all randomness bits are constantly 0.
